// File: rtl/imc_row_sequencer.sv
// imc_row_sequencer: command sequencer for the IMC macro's 128-row dual-read/single-write wordline decoder
// Ports: clk/rst (sync, active-high); cmd_valid/cmd_ready/cmd_op/cmd_addr_a/b/d/cmd_wdata command channel
//        (op 00 NOP, 01 READ, 10 WRITE, 11 COMPUTE); read_address1/2, read_enable1/2, write_address,
//        write_enable, write_data to the decoder and write drivers; sense_data sensed bitline value;
//        rsp_valid/rsp_ready/rsp_data result channel carrying the captured sense value.
// Define IMC_CMD_FIFO_EN to place a 2-entry command FIFO ahead of the FSM.
module imc_row_sequencer #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 32,
    parameter int SENSE_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr_a,
    input  logic [ADDR_W-1:0] cmd_addr_b,
    input  logic [ADDR_W-1:0] cmd_addr_d,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic [ADDR_W-1:0] read_address1,
    output logic [ADDR_W-1:0] read_address2,
    output logic              read_enable1,
    output logic              read_enable2,
    output logic [ADDR_W-1:0] write_address,
    output logic              write_enable,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] sense_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data
);
    localparam logic [1:0] OP_NOP = 2'b00, OP_WRITE = 2'b10, OP_COMP = 2'b11;
    localparam int CW = SENSE_LAT > 1 ? $clog2(SENSE_LAT) : 1;
    typedef enum logic [1:0] {IDLE, ACT, WB, RSP} state_t;
    state_t            state_q;
    logic [CW-1:0]     sc_q;
    logic              comp_q;
    logic [ADDR_W-1:0] d_q;
    logic              s_go;
    logic [1:0]        s_op;
    logic [ADDR_W-1:0] s_a, s_b, s_d;
    logic [DATA_W-1:0] s_wdata;
`ifdef IMC_CMD_FIFO_EN
    localparam int EW = 2 + 3 * ADDR_W + DATA_W;
    logic [EW-1:0] fifo_q [2];
    logic          wp_q, rp_q, push, pop;
    logic [1:0]    cnt_q, cnt_d;
    assign cmd_ready = !rst && cnt_q != 2'd2;
    assign push = cmd_valid && cmd_ready && cmd_op != OP_NOP;
    assign pop = state_q == IDLE && cnt_q != 2'd0;
    assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    assign s_go = pop;
    assign {s_op, s_a, s_b, s_d, s_wdata} = fifo_q[rp_q];
    always_ff @(posedge clk)
        if (push) fifo_q[wp_q] <= {cmd_op, cmd_addr_a, cmd_addr_b, cmd_addr_d, cmd_wdata};
    always_ff @(posedge clk)
        if (rst) begin
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            wp_q  <= wp_q ^ push;
            rp_q  <= rp_q ^ pop;
            cnt_q <= cnt_d;
        end
`else
    assign cmd_ready = !rst && state_q == IDLE;
    assign s_go = cmd_valid && cmd_ready;
    assign {s_op, s_a, s_b, s_d, s_wdata} = {cmd_op, cmd_addr_a, cmd_addr_b, cmd_addr_d, cmd_wdata};
`endif
    always_ff @(posedge clk)
        if (rst) begin
            state_q       <= IDLE;
            sc_q          <= '0;
            comp_q        <= 1'b0;
            d_q           <= '0;
            read_address1 <= '0;
            read_address2 <= '0;
            read_enable1  <= 1'b0;
            read_enable2  <= 1'b0;
            write_address <= '0;
            write_enable  <= 1'b0;
            write_data    <= '0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
        end else begin
            case (state_q)
                IDLE: if (s_go && s_op != OP_NOP) begin
                    comp_q <= s_op == OP_COMP;
                    d_q    <= s_d;
                    if (s_op == OP_WRITE) begin
                        state_q       <= WB;
                        write_enable  <= 1'b1;
                        write_address <= s_d;
                        write_data    <= s_wdata;
                    end else begin
                        state_q       <= ACT;
                        sc_q          <= CW'(SENSE_LAT - 1);
                        read_address1 <= s_a;
                        read_address2 <= s_op == OP_COMP ? s_b : read_address2;
                        read_enable1  <= 1'b1;
                        // a single row pulled up once is enough when both operands name the same row
                        read_enable2  <= s_op == OP_COMP && s_a != s_b;
                    end
                end
                ACT: if (sc_q == '0) begin
                    read_enable1 <= 1'b0;
                    read_enable2 <= 1'b0;
                    rsp_data     <= sense_data;
                    state_q      <= comp_q ? WB : RSP;
                    rsp_valid    <= !comp_q;
                    write_enable <= comp_q;
                    if (comp_q) begin
                        write_address <= d_q;
                        write_data    <= sense_data;
                    end
                end else begin
                    sc_q <= sc_q - CW'(1);
                end
                WB: begin
                    write_enable <= 1'b0;
                    state_q      <= comp_q ? RSP : IDLE;
                    rsp_valid    <= comp_q;
                end
                RSP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
endmodule

// File: tb/tb_imc_row_sequencer.sv
// tb_imc_row_sequencer: scoreboard bench for imc_row_sequencer with a behavioural row array as sense model
module tb_imc_row_sequencer;
`ifdef IMC_CMD_FIFO_EN
    localparam int EX = 1;
`else
    localparam int EX = 0;
`endif
    logic        clk = 1'b0, rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [6:0]  cmd_addr_a = '0, cmd_addr_b = '0, cmd_addr_d = '0;
    logic [31:0] cmd_wdata = '0;
    logic [6:0]  read_address1, read_address2, write_address;
    logic        read_enable1, read_enable2, write_enable;
    logic [31:0] write_data, sense_data, rsp_data;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] mem [128];
    logic [31:0] exp_q [$];
    int          checks = 0, failures = 0, viol = 0;

    imc_row_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_addr_d(cmd_addr_d), .cmd_wdata(cmd_wdata),
        .read_address1(read_address1), .read_address2(read_address2),
        .read_enable1(read_enable1), .read_enable2(read_enable2),
        .write_address(write_address), .write_enable(write_enable), .write_data(write_data),
        .sense_data(sense_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_init(input int i);
        case (i)
            3:       return 32'h0000_FFFF;
            5:       return 32'hA5A5_0001;
            9:       return 32'hFFFF_FF00;
            40:      return 32'h1234_5678;
            default: return (32'(i) * 32'h9E37_79B9) ^ 32'h0F0F_0000;
        endcase
    endfunction

    // two active rows sense as the bitwise AND of their contents
    assign sense_data = read_enable1 ? (read_enable2 ? mem[read_address1] & mem[read_address2]
                                                     : mem[read_address1]) : 32'h0;

    always @(posedge clk)
        if (rst) for (int i = 0; i < 128; i++) mem[i] <= mem_init(i);
        else if (write_enable) mem[write_address] <= write_data;

    always @(negedge clk)
        if (!rst && write_enable && (read_enable1 || read_enable2)) viol <= viol + 1;

    initial begin
        #400000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [6:0] a, b, d, input logic [31:0] wd);
        cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_addr_d = d; cmd_wdata = wd; cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !cmd_ready; i++) tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready got=%b exp=1", cmd_ready);
        end
        if (op == 2'b01) exp_q.push_back(mem[a]);
        else if (op == 2'b11) exp_q.push_back(a == b ? mem[a] : mem[a] & mem[b]);
        tick();
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_addr_a = 7'($urandom); cmd_addr_b = 7'($urandom);
        cmd_addr_d = 7'($urandom); cmd_wdata = $urandom;
    endtask

    task automatic test_reset;
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        tick(); tick();
        checks++;
        if ({cmd_ready, rsp_valid, read_enable1, read_enable2, write_enable} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000", {cmd_ready, rsp_valid, read_enable1, read_enable2, write_enable});
        end
        checks++;
        if ({read_address1, read_address2, write_address} !== 21'h0) begin
            failures++;
            $display("FAIL reset_addr got=%h exp=0", {read_address1, read_address2, write_address});
        end
        checks++;
        if ({write_data, rsp_data} !== 64'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {write_data, rsp_data});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_rise got=%b exp=1", cmd_ready);
        end
    endtask

    task automatic test_read;
        logic [31:0] e;
        send(2'b01, 7'd5, 7'd0, 7'd0, 32'h0);
        for (int i = 0; i < EX; i++) tick();
        checks++;
        if ({read_enable1, read_enable2, write_enable, rsp_valid, read_address1} !== {4'b1000, 7'd5}) begin
            failures++;
            $display("FAIL read_act got=%b_%0d exp=1000_5", {read_enable1, read_enable2, write_enable, rsp_valid}, read_address1);
        end
        tick();
        e = exp_q.size() != 0 ? exp_q.pop_front() : 32'hxxxx_xxxx;
        checks++;
        if ({rsp_valid, read_enable1, read_enable2, write_enable} !== 4'b1000 || rsp_data !== e || rsp_data !== 32'hA5A5_0001) begin
            failures++;
            $display("FAIL read_rsp got=%b_%h exp=1000_%h", {rsp_valid, read_enable1, read_enable2, write_enable}, rsp_data, e);
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            failures++;
            $display("FAIL read_done got=%b exp=01", {rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_compute(input logic [6:0] a, b, d, input logic [31:0] want);
        logic [31:0] e;
        send(2'b11, a, b, d, 32'h0);
        for (int i = 0; i < EX; i++) tick();
        checks++;
        if ({read_enable1, read_enable2, write_enable, read_address1} !== {1'b1, a != b, 1'b0, a} || (a != b && read_address2 !== b)) begin
            failures++;
            $display("FAIL compute_act got=%b_%0d_%0d exp=%b_%0d_%0d", {read_enable1, read_enable2, write_enable}, read_address1, read_address2, {1'b1, a != b, 1'b0}, a, b);
        end
        tick();
        checks++;
        if ({write_enable, read_enable1, read_enable2, rsp_valid} !== 4'b1000 || write_address !== d || write_data !== want) begin
            failures++;
            $display("FAIL compute_wb got=%b_%0d_%h exp=1000_%0d_%h", {write_enable, read_enable1, read_enable2, rsp_valid}, write_address, write_data, d, want);
        end
        tick();
        e = exp_q.size() != 0 ? exp_q.pop_front() : 32'hxxxx_xxxx;
        checks++;
        if ({rsp_valid, write_enable} !== 2'b10 || rsp_data !== e || rsp_data !== want) begin
            failures++;
            $display("FAIL compute_rsp got=%b_%h exp=10_%h", {rsp_valid, write_enable}, rsp_data, want);
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

    task automatic test_writeback_readout;
        logic [31:0] e;
        send(2'b01, 7'd60, 7'd0, 7'd0, 32'h0);
        for (int i = 0; i < EX + 1; i++) tick();
        e = exp_q.size() != 0 ? exp_q.pop_front() : 32'hxxxx_xxxx;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== e || rsp_data !== 32'h1234_5678) begin
            failures++;
            $display("FAIL writeback_read got=%b_%h exp=1_12345678", rsp_valid, rsp_data);
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

    task automatic test_write;
        int bad = 0;
        send(2'b10, 7'd0, 7'd0, 7'd127, 32'hDEAD_BEEF);
        for (int i = 0; i < EX; i++) tick();
        checks++;
        if ({write_enable, read_enable1, read_enable2, rsp_valid} !== 4'b1000 || write_address !== 7'd127 || write_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL write_pulse got=%b_%0d_%h exp=1000_127_deadbeef", {write_enable, read_enable1, read_enable2, rsp_valid}, write_address, write_data);
        end
        tick();
        checks++;
        if ({write_enable, cmd_ready} !== 2'b01) begin
            failures++;
            $display("FAIL write_return got=%b exp=01", {write_enable, cmd_ready});
        end
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid || write_enable) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL write_quiet got=%0d exp=0", bad);
        end
    endtask

    task automatic test_nop;
        send(2'b00, 7'd5, 7'd9, 7'd17, 32'h1);
        tick();
        checks++;
        if ({read_enable1, write_enable, rsp_valid, cmd_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL nop_dropped got=%b exp=0001", {read_enable1, write_enable, rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] e;
        send(2'b01, 7'd127, 7'd0, 7'd0, 32'h0);
        for (int i = 0; i < EX + 1; i++) tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
`ifdef IMC_CMD_FIFO_EN
            if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEAD_BEEF) begin
`else
            if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEAD_BEEF || cmd_ready !== 1'b0) begin
`endif
                failures++;
                $display("FAIL hold_rsp got=%b_%h_%b exp=1_deadbeef_0", rsp_valid, rsp_data, cmd_ready);
            end
            tick();
        end
        e = exp_q.size() != 0 ? exp_q.pop_front() : 32'hxxxx_xxxx;
        checks++;
        if (rsp_data !== e) begin
            failures++;
            $display("FAIL hold_scoreboard got=%h exp=%h", rsp_data, e);
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            failures++;
            $display("FAIL hold_release got=%b exp=01", {rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_back_to_back;
        logic [6:0]  a;
        logic [31:0] e;
        int          w;
        for (int k = 0; k < 6; k++) begin
            a = 7'($urandom_range(0, 127));
            send(2'b01, a, 7'd0, 7'd0, 32'h0);
            w = 0;
            while (!rsp_valid && w < 20) begin
                tick();
                w++;
            end
            e = exp_q.size() != 0 ? exp_q.pop_front() : 32'hxxxx_xxxx;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== e) begin
                failures++;
                $display("FAIL b2b_read addr=%0d got=%b_%h exp=1_%h", a, rsp_valid, rsp_data, e);
            end
            rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid;
        int bad = 0;
`ifdef IMC_CMD_FIFO_EN
        rsp_ready = 1'b0;
        send(2'b01, 7'd5, 7'd0, 7'd0, 32'h0);
        send(2'b11, 7'd3, 7'd9, 7'd17, 32'h0);
        send(2'b01, 7'd9, 7'd0, 7'd0, 32'h0);
`else
        send(2'b11, 7'd3, 7'd9, 7'd17, 32'h0);
        checks++;
        if ({read_enable1, write_enable} !== 2'b10) begin
            failures++;
            $display("FAIL midrst_in_act got=%b exp=10", {read_enable1, write_enable});
        end
`endif
        rst = 1'b1;
        tick();
        checks++;
        if ({cmd_ready, rsp_valid, read_enable1, read_enable2, write_enable} !== 5'b0 ||
            {read_address1, read_address2, write_address, write_data, rsp_data} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs got=%b_%h exp=00000_0", {cmd_ready, rsp_valid, read_enable1, read_enable2, write_enable},
                     {read_address1, read_address2, write_address, write_data, rsp_data});
        end
        rst = 1'b0;
        exp_q.delete();
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid || write_enable || read_enable1) bad++;
            tick();
        end
        rsp_ready = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL midrst_abandoned got=%0d exp=0", bad);
        end
    endtask

    task automatic test_invariant;
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL rw_exclusive got=%0d exp=0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_compute(7'd3, 7'd9, 7'd17, 32'h0000_FF00);
        test_compute(7'd40, 7'd40, 7'd60, 32'h1234_5678);
        test_writeback_readout();
        test_write();
        test_nop();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_invariant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
